// File: rtl/fir_sm_collector_if.sv
// Bundle for the collector: FIR output stream (sm side) plus the host AXI-Lite
// register port. There is no write response channel.
interface fir_sm_collector_if #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
);
  logic                   s_tvalid;
  logic [pDATA_WIDTH-1:0] s_tdata;
  logic                   s_tlast;
  logic                   s_tready;

  logic                   awvalid;
  logic [pADDR_WIDTH-1:0] awaddr;
  logic                   awready;
  logic                   wvalid;
  logic [pDATA_WIDTH-1:0] wdata;
  logic                   wready;
  logic                   arvalid;
  logic [pADDR_WIDTH-1:0] araddr;
  logic                   arready;
  logic                   rvalid;
  logic [pDATA_WIDTH-1:0] rdata;
  logic                   rready;

  modport master (
    output s_tvalid, s_tdata, s_tlast,
    input  s_tready,
    output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    input  awready, wready, arready, rvalid, rdata
  );

  modport slave (
    input  s_tvalid, s_tdata, s_tlast,
    output s_tready,
    input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    output awready, wready, arready, rvalid, rdata
  );
endinterface

// File: rtl/fir_sm_collector.sv
// Collects FIR output beats into a result buffer, checks frame length against
// LEN, and exposes status, count and results over AXI-Lite.
module fir_sm_collector #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int DEPTH       = 64
) (
  input  logic              axis_clk,
  input  logic              axis_rst_n,
  fir_sm_collector_if.slave bus,
  output logic              irq
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WW = pADDR_WIDTH - 2;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  // Register map in word units (byte address >> 2)
  localparam logic [WW-1:0] CTRL_W   = WW'(0);
  localparam logic [WW-1:0] LEN_W    = WW'(1);
  localparam logic [WW-1:0] COUNT_W  = WW'(2);
  localparam logic [WW-1:0] RES_BASE = WW'(64);
  localparam logic [WW-1:0] RES_END  = WW'(64 + DEPTH);
  localparam logic [pDATA_WIDTH-1:0] DEPTH_D = pDATA_WIDTH'(DEPTH);

  logic [1:0]             state_reg, state_next;
  logic [pDATA_WIDTH-1:0] count_reg, count_next;
  logic [pDATA_WIDTH-1:0] len_reg, len_next;
  logic                   ovf_reg, ovf_next;
  logic                   early_reg, early_next;
  logic                   late_reg, late_next;
  logic                   rvalid_reg;
  logic [pDATA_WIDTH-1:0] rdata_reg;
  logic [pDATA_WIDTH-1:0] rd_mux;
  logic [pDATA_WIDTH-1:0] mem [DEPTH];

  logic                   beat, wr_en, rd_fire, mem_we, len_hit;
  logic [pDATA_WIDTH-1:0] count_inc;
  logic [WW-1:0]          wr_word, rd_word;
  logic                   unused_addr_bits;

  assign wr_en         = bus.awvalid && bus.wvalid;
  assign bus.awready   = wr_en;
  assign bus.wready    = wr_en;
  assign bus.s_tready  = (state_reg == CAPTURE);
  assign irq           = (state_reg == DONE);
  assign bus.arready   = !rvalid_reg;
  assign bus.rvalid    = rvalid_reg;
  assign bus.rdata     = rdata_reg;

  assign beat      = bus.s_tvalid && (state_reg == CAPTURE);
  assign rd_fire   = bus.arvalid && !rvalid_reg;
  assign wr_word   = bus.awaddr[pADDR_WIDTH-1:2];
  assign rd_word   = bus.araddr[pADDR_WIDTH-1:2];
  assign count_inc = count_reg + pDATA_WIDTH'(1);
  assign len_hit   = (count_inc == len_reg);
  assign unused_addr_bits = ^{bus.awaddr[1:0], bus.araddr[1:0]};

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    len_next   = len_reg;
    ovf_next   = ovf_reg;
    early_next = early_reg;
    late_next  = late_reg;
    mem_we     = 1'b0;

    if (beat) begin
      // Beats past the buffer are still counted so COUNT shows the real frame size
      mem_we     = (count_reg < DEPTH_D);
      ovf_next   = ovf_reg | ~mem_we;
      count_next = count_inc;
      if (bus.s_tlast || len_hit)
        state_next = DONE;
      if (bus.s_tlast && (count_inc < len_reg))
        early_next = 1'b1;
      if (len_hit && !bus.s_tlast)
        late_next = 1'b1;
    end

    // Host commands override whatever the stream did this cycle
    if (wr_en) begin
      if (wr_word == CTRL_W) begin
        if (bus.wdata[1] || bus.wdata[0]) begin
          count_next = '0;
          ovf_next   = 1'b0;
          early_next = 1'b0;
          late_next  = 1'b0;
          if (bus.wdata[1])
            state_next = IDLE;
          else
            state_next = (len_reg == '0) ? DONE : CAPTURE;
        end
      end else if (wr_word == LEN_W && state_reg != CAPTURE) begin
        len_next = bus.wdata;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    if (rd_word == CTRL_W)
      rd_mux[4:0] = {late_reg, early_reg, ovf_reg, state_reg == DONE, state_reg == CAPTURE};
    else if (rd_word == LEN_W)
      rd_mux = len_reg;
    else if (rd_word == COUNT_W)
      rd_mux = count_reg;
    else if (rd_word >= RES_BASE && rd_word < RES_END)
      rd_mux = mem[rd_word[AW-1:0]];
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      len_reg    <= '0;
      ovf_reg    <= 1'b0;
      early_reg  <= 1'b0;
      late_reg   <= 1'b0;
      rvalid_reg <= 1'b0;
      rdata_reg  <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      len_reg   <= len_next;
      ovf_reg   <= ovf_next;
      early_reg <= early_next;
      late_reg  <= late_next;
      if (rd_fire) begin
        rvalid_reg <= 1'b1;
        rdata_reg  <= rd_mux;
      end else if (bus.rready) begin
        rvalid_reg <= 1'b0;
      end
    end
  end

  // Buffer has no reset; a same-cycle read sees the old entry
  always_ff @(posedge axis_clk) begin
    if (mem_we)
      mem[count_reg[AW-1:0]] <= bus.s_tdata;
  end
endmodule

// File: tb/tb_fir_sm_collector.sv
// Bench for fir_sm_collector: reads are scoreboarded (expected value queued at
// issue, compared when rvalid&&rready), stream/handshake checks are inline.
module tb_fir_sm_collector;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic irq;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [31:0] exp_mem [64];
  int          mcount = 0;
  logic [31:0] mon_exp;
  string       mon_name;

  fir_sm_collector_if #(.pADDR_WIDTH(12), .pDATA_WIDTH(32)) bus ();

  fir_sm_collector #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .DEPTH(64)) dut (
    .axis_clk  (clk),
    .axis_rst_n(rst_n),
    .bus       (bus.slave),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // Read scoreboard
  always @(negedge clk) begin
    if (bus.rvalid && bus.rready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected got=%h required=none", bus.rdata);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        if (bus.rdata !== mon_exp) begin
          errors++;
          $display("FAIL %s got=%h required=%h", mon_name, bus.rdata, mon_exp);
        end else begin
          $display("read %s data=%h", mon_name, bus.rdata);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic idle_inputs();
    bus.s_tvalid = 0; bus.s_tdata = '0; bus.s_tlast = 0;
    bus.awvalid = 0; bus.awaddr = '0; bus.wvalid = 0; bus.wdata = '0;
    bus.arvalid = 0; bus.araddr = '0; bus.rready = 0;
  endtask

  task automatic axil_write(input logic [11:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.awvalid = 1; bus.wvalid = 1; bus.awaddr = addr; bus.wdata = data;
    @(negedge clk);
    bus.awvalid = 0; bus.wvalid = 0;
    $display("write addr=%h data=%h", addr, data);
  endtask

  task automatic axil_read(input logic [11:0] addr, input logic [31:0] expv, input string nm);
    int n;
    exp_q.push_back(expv);
    name_q.push_back(nm);
    @(negedge clk);
    bus.arvalid = 1; bus.araddr = addr; bus.rready = 1;
    @(negedge clk);
    bus.arvalid = 0;
    n = 0;
    while (!bus.rvalid && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (n == 8) begin
      checks++; errors++;
      $display("FAIL %s_timeout rvalid=0 required=1", nm);
      void'(exp_q.pop_front());
      void'(name_q.pop_front());
    end
    @(negedge clk);
    bus.rready = 0;
  endtask

  task automatic arm();
    axil_write(12'h000, 32'h1);
    mcount = 0;
  endtask

  task automatic send_beat(input logic [31:0] data, input bit last, input bit accept, output logic rdy);
    @(negedge clk);
    bus.s_tvalid = 1; bus.s_tdata = data; bus.s_tlast = last;
    rdy = bus.s_tready;
    if (accept) begin
      if (mcount < 64) exp_mem[mcount] = data;
      mcount++;
    end
    $display("beat data=%h last=%0d tready=%0d", data, last, rdy);
  endtask

  task automatic stream_idle();
    @(negedge clk);
    bus.s_tvalid = 0; bus.s_tlast = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    checks++;
    if ({bus.s_tready, irq, bus.rvalid, bus.arready, bus.awready, bus.wready} !== 6'b000100) begin
      errors++;
      $display("FAIL reset_outputs got=%b required=000100",
               {bus.s_tready, irq, bus.rvalid, bus.arready, bus.awready, bus.wready});
    end
    checks++;
    if (bus.rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata got=%h required=0", bus.rdata);
    end
    axil_read(12'h000, 32'h0, "reset_status");
    axil_read(12'h004, 32'h0, "reset_len");
    axil_read(12'h008, 32'h0, "reset_count");
    @(negedge clk);
    bus.awvalid = 1; bus.awaddr = 12'h020;
    #1;
    checks++;
    if (bus.awready !== 1'b0) begin
      errors++; $display("FAIL aw_only_ready got=%b required=0", bus.awready);
    end
    bus.wvalid = 1; bus.wdata = 32'hFFFF_FFFF;
    #1;
    checks++;
    if ({bus.awready, bus.wready} !== 2'b11) begin
      errors++; $display("FAIL aw_w_ready got=%b required=11", {bus.awready, bus.wready});
    end
    @(negedge clk);
    bus.awvalid = 0; bus.wvalid = 0;
    axil_read(12'h000, 32'h0, "unmapped_write_status");
  endtask

  task automatic test_normal_frame();
    logic rdy;
    int   nlow = 0;
    axil_write(12'h004, 32'd5);
    arm();
    checks++;
    if (bus.s_tready !== 1'b1) begin
      errors++; $display("FAIL armed_tready got=%b required=1", bus.s_tready);
    end
    for (int i = 1; i <= 5; i++) begin
      send_beat(32'(i), i == 5, 1'b1, rdy);
      if (rdy !== 1'b1) nlow++;
    end
    stream_idle();
    checks++;
    if (nlow != 0) begin
      errors++; $display("FAIL normal_tready_low got=%0d required=0", nlow);
    end
    checks++;
    if ({irq, bus.s_tready} !== 2'b10) begin
      errors++; $display("FAIL normal_done got=%b required=10", {irq, bus.s_tready});
    end
    axil_read(12'h000, 32'h02, "normal_status");
    axil_read(12'h008, 32'd5, "normal_count");
    for (int i = 0; i < 5; i++)
      axil_read(12'(12'h100 + 4 * i), exp_mem[i], $sformatf("normal_result%0d", i));
    axil_read(12'h00C, 32'h0, "unmapped_read");
  endtask

  task automatic test_early_last();
    logic rdy;
    axil_write(12'h004, 32'd5);
    arm();
    send_beat(32'd7, 1'b0, 1'b1, rdy);
    send_beat(32'd8, 1'b0, 1'b1, rdy);
    send_beat(32'd9, 1'b1, 1'b1, rdy);
    stream_idle();
    checks++;
    if ({irq, bus.s_tready} !== 2'b10) begin
      errors++; $display("FAIL early_done got=%b required=10", {irq, bus.s_tready});
    end
    axil_read(12'h000, 32'h0A, "early_status");
    axil_read(12'h008, 32'd3, "early_count");
    axil_read(12'h108, exp_mem[2], "early_result2");
    axil_read(12'h10C, exp_mem[3], "early_result3_kept");
  endtask

  task automatic test_late_last();
    logic rdy;
    axil_write(12'h004, 32'd4);
    arm();
    for (int i = 0; i < 4; i++)
      send_beat(32'(32'h11 + i), 1'b0, 1'b1, rdy);
    send_beat(32'h55, 1'b1, 1'b0, rdy);
    checks++;
    if (rdy !== 1'b0) begin
      errors++; $display("FAIL late_fifth_tready got=%b required=0", rdy);
    end
    stream_idle();
    axil_read(12'h000, 32'h12, "late_status");
    axil_read(12'h008, 32'd4, "late_count");
    axil_read(12'h10C, exp_mem[3], "late_result3");
    axil_read(12'h110, exp_mem[4], "late_result4_untouched");
  endtask

  task automatic test_overflow();
    logic rdy;
    int   nlow = 0;
    axil_write(12'h000, 32'h2);
    axil_read(12'h000, 32'h0, "clear_status");
    axil_write(12'h004, 32'd70);
    arm();
    for (int i = 0; i < 70; i++) begin
      send_beat(32'(i), i == 69, 1'b1, rdy);
      if (rdy !== 1'b1) nlow++;
    end
    stream_idle();
    checks++;
    if (nlow != 0) begin
      errors++; $display("FAIL ovf_tready_low got=%0d required=0", nlow);
    end
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL ovf_irq got=%b required=1", irq);
    end
    axil_read(12'h008, 32'd70, "ovf_count");
    axil_read(12'h000, 32'h06, "ovf_status");
    axil_read(12'h1FC, exp_mem[63], "ovf_result63");
    axil_read(12'h100, exp_mem[0], "ovf_result0");
  endtask

  task automatic test_read_hold_and_clear();
    logic rdy;
    axil_write(12'h004, 32'd10);
    arm();
    send_beat(32'hA0, 1'b0, 1'b1, rdy);
    send_beat(32'hA1, 1'b0, 1'b1, rdy);
    stream_idle();
    axil_write(12'h004, 32'd3);
    exp_q.push_back(32'd2);
    name_q.push_back("hold_count");
    @(negedge clk);
    bus.arvalid = 1; bus.araddr = 12'h008; bus.rready = 0;
    @(negedge clk);
    bus.arvalid = 0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({bus.rvalid, bus.arready} !== 2'b10 || bus.rdata !== 32'd2) begin
        errors++;
        $display("FAIL hold_cycle%0d rvalid_arready=%b rdata=%h required=10/%h",
                 k, {bus.rvalid, bus.arready}, bus.rdata, 32'd2);
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 bus.rready = 1;
    @(negedge clk);
    @(negedge clk);
    bus.rready = 0;
    checks++;
    if (bus.rvalid !== 1'b0) begin
      errors++; $display("FAIL hold_release rvalid=%b required=0", bus.rvalid);
    end
    axil_write(12'h000, 32'h2);
    checks++;
    if ({bus.s_tready, irq} !== 2'b00) begin
      errors++; $display("FAIL clear_mid got=%b required=00", {bus.s_tready, irq});
    end
    axil_read(12'h004, 32'd10, "len_write_ignored");
    axil_read(12'h000, 32'h0, "clear_mid_status");
    axil_read(12'h008, 32'h0, "clear_mid_count");
    axil_read(12'h104, exp_mem[1], "clear_buffer_kept");
  endtask

  task automatic test_len_zero();
    axil_write(12'h004, 32'd0);
    arm();
    checks++;
    if ({irq, bus.s_tready} !== 2'b10) begin
      errors++; $display("FAIL len0_done got=%b required=10", {irq, bus.s_tready});
    end
    axil_read(12'h008, 32'h0, "len0_count");
    axil_read(12'h000, 32'h02, "len0_status");
    axil_write(12'h000, 32'h3);
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL clear_wins_irq got=%b required=0", irq);
    end
    axil_read(12'h000, 32'h0, "clear_wins_status");
  endtask

  task automatic test_async_reset();
    logic rdy;
    axil_write(12'h004, 32'd8);
    arm();
    send_beat(32'hC0, 1'b0, 1'b1, rdy);
    send_beat(32'hC1, 1'b0, 1'b1, rdy);
    stream_idle();
    @(negedge clk);
    bus.arvalid = 1; bus.araddr = 12'h008; bus.rready = 0;
    @(negedge clk);
    bus.arvalid = 0;
    checks++;
    if ({bus.s_tready, bus.rvalid} !== 2'b11) begin
      errors++; $display("FAIL pre_reset got=%b required=11", {bus.s_tready, bus.rvalid});
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({bus.s_tready, irq, bus.rvalid, bus.arready} !== 4'b0001 || bus.rdata !== 32'h0) begin
      errors++;
      $display("FAIL async_reset outs=%b rdata=%h required=0001/0",
               {bus.s_tready, irq, bus.rvalid, bus.arready}, bus.rdata);
    end
    @(negedge clk);
    rst_n = 1;
    axil_read(12'h000, 32'h0, "post_reset_status");
    axil_read(12'h008, 32'h0, "post_reset_count");
    axil_read(12'h004, 32'h0, "post_reset_len");
  endtask

  initial begin
    test_reset();
    test_normal_frame();
    test_early_last();
    test_late_last();
    test_overflow();
    test_read_hold_and_clear();
    test_len_zero();
    test_async_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_left got=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
